// File: rtl/out_link_pkg.sv
// out_link_pkg -- shared types and constants for the out_link_tx block.
//   state_t      : link sender FSM states
//   TMO_W        : width of the per-state ack timeout counter
//   SYNC_STAGES  : flops in the link_ack / link_nak synchronisers
//   RESEND_MAX   : resends allowed per word after a NAK (parity build only)
package out_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int TMO_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int RESEND_MAX  = 3;
    localparam int RESEND_W    = 2;

endpackage

// File: rtl/out_link_fifo.sv
// out_link_fifo -- word FIFO between the core and the link sender.
//   clk, rst : clock, asynchronous active-high reset (discards contents)
//   push/din : write request and data; ignored when full (rej pulses instead)
//   pop/dout : read request and head-of-queue data (dout valid while !empty)
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH, from the pre-edge count
//   empty    : count == 0
//   rej      : push attempted while full this cycle
// DEPTH must be a power of two so the pointers wrap naturally.
module out_link_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     rej
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rej     = push && full;
    assign dout    = mem[rptr];

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_link_tx.sv
// out_link_tx -- queues core words and sends them over a parallel
// inter-board link using a four-phase req/ack handshake.
//   clk, rst     : clock, asynchronous active-high reset
//   wr_en/wr_data: push a word into the FIFO
//   full, level  : FIFO full flag and occupancy
//   idle         : FIFO empty and sender in IDLE
//   link_data    : registered link data bus, held through the handshake
//   link_sent    : registered request strobe
//   link_ack     : asynchronous acknowledge, double-flop synchronised
//   err_timeout  : sticky, set when an ack edge does not arrive in time
//   err_ovf      : sticky, set when a word is written while full
//   err_clr      : clears both sticky flags (wins over a same-cycle set)
// Optional build macro OUT_LINK_PARITY_EN adds link_par (even parity of
// link_data) and link_nak (synchronised NAK that triggers a resend of the
// same word, up to RESEND_MAX times).
module out_link_tx
    import out_link_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     idle,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         link_data,
    output logic                     link_sent,
    input  logic                     link_ack,
`ifdef OUT_LINK_PARITY_EN
    output logic                     link_par,
    input  logic                     link_nak,
`endif
    output logic                     err_timeout,
    output logic                     err_ovf,
    input  logic                     err_clr
);

    localparam logic [3:0]       SETUP_LOAD = 4'(SETUP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   far_busy;
    logic [3:0]             setup_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   sent_n;
    logic                   setup_ld;
    logic                   tmo_evt;

    logic                   fifo_pop;
    logic [WIDTH-1:0]       fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_rej;

`ifdef OUT_LINK_PARITY_EN
    localparam logic [RESEND_W-1:0] RESEND_LIM = RESEND_W'(RESEND_MAX);
    logic [SYNC_STAGES-1:0] nak_sync;
    logic                   nak_s;
    logic [RESEND_W-1:0]    resend_cnt;
    logic                   resend_pend;
    logic                   resend_inc;
`endif

    out_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (level),
        .full  (full),
        .empty (fifo_empty),
        .rej   (fifo_rej)
    );

    assign ack_s = ack_sync[SYNC_STAGES-1];
`ifdef OUT_LINK_PARITY_EN
    assign nak_s    = nak_sync[SYNC_STAGES-1];
    // A new or repeated request waits until the far end has released both lines.
    assign far_busy = ack_s | nak_s;
`else
    assign far_busy = ack_s;
`endif

    assign idle = fifo_empty && (state == IDLE);

    always_comb begin
        state_n  = state;
        sent_n   = link_sent;
        fifo_pop = 1'b0;
        setup_ld = 1'b0;
        tmo_evt  = 1'b0;
`ifdef OUT_LINK_PARITY_EN
        resend_inc = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty && !far_busy) begin
                    fifo_pop = 1'b1;
                    setup_ld = 1'b1;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt == '0) begin
                    sent_n  = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    sent_n  = 1'b0;
                    state_n = RELEASE;
`ifdef OUT_LINK_PARITY_EN
                end else if (nak_s) begin
                    sent_n  = 1'b0;
                    state_n = RELEASE;
                    // Out of resends: report it and drop the word.
                    if (resend_cnt == RESEND_LIM) tmo_evt    = 1'b1;
                    else                          resend_inc = 1'b1;
`endif
                end else if (tmo_cnt == '0) begin
                    // The word is abandoned, not retried.
                    sent_n  = 1'b0;
                    tmo_evt = 1'b1;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!far_busy) begin
`ifdef OUT_LINK_PARITY_EN
                    if (resend_pend) begin
                        setup_ld = 1'b1;
                        state_n  = SETUP;
                    end else begin
                        state_n  = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end else if (tmo_cnt == '0) begin
                    tmo_evt = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ack_sync    <= '0;
            setup_cnt   <= '0;
            tmo_cnt     <= '0;
            link_data   <= '0;
            link_sent   <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state     <= state_n;
            ack_sync  <= {ack_sync[SYNC_STAGES-2:0], link_ack};
            link_sent <= sent_n;
            if (fifo_pop) link_data <= fifo_dout;

            if (setup_ld)                              setup_cnt <= SETUP_LOAD;
            else if (state == SETUP && setup_cnt != '0) setup_cnt <= setup_cnt - 1'b1;

            // Timeout budget restarts on every state change.
            if (state_n != state)   tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

            if (err_clr)      err_timeout <= 1'b0;
            else if (tmo_evt) err_timeout <= 1'b1;

            if (err_clr)       err_ovf <= 1'b0;
            else if (fifo_rej) err_ovf <= 1'b1;
        end
    end

`ifdef OUT_LINK_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nak_sync    <= '0;
            link_par    <= 1'b0;
            resend_cnt  <= '0;
            resend_pend <= 1'b0;
        end else begin
            nak_sync <= {nak_sync[SYNC_STAGES-2:0], link_nak};
            if (fifo_pop) link_par <= ^fifo_dout;

            if (fifo_pop)        resend_cnt <= '0;
            else if (resend_inc) resend_cnt <= resend_cnt + 1'b1;

            if (state == RELEASE && state_n != RELEASE) resend_pend <= 1'b0;
            else if (resend_inc)                        resend_pend <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_out_link_tx.sv
// tb_out_link_tx -- scoreboard bench for out_link_tx.
// Every word the reference model expects on the link is queued in exp_q;
// a monitor pops it on each rising link_sent and compares link_data.
// A far-end responder process models the other board (normal, stalled,
// silent or manually driven).
module tb_out_link_tx;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SETUP = 2;
    localparam int TMO   = 10;
    localparam int LW    = $clog2(DEPTH) + 1;

    localparam int FE_NORMAL = 0;
    localparam int FE_STALL  = 1;
    localparam int FE_SILENT = 2;
    localparam int FE_MANUAL = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             idle;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] link_data;
    logic             link_sent;
    logic             link_ack;
    logic             link_nak;
    logic             err_timeout;
    logic             err_ovf;
    logic             err_clr;
`ifdef OUT_LINK_PARITY_EN
    logic             link_par;
`endif

    int tests = 0;
    int fails = 0;
    int fe_mode = FE_NORMAL;
    int ack_dly = 1;
    int naks_left = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    out_link_tx #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .idle       (idle),
        .level      (level),
        .link_data  (link_data),
        .link_sent  (link_sent),
        .link_ack   (link_ack),
`ifdef OUT_LINK_PARITY_EN
        .link_par   (link_par),
        .link_nak   (link_nak),
`endif
        .err_timeout(err_timeout),
        .err_ovf    (err_ovf),
        .err_clr    (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Far end of the link.
    initial begin
        int cnt = 0;
        link_ack = 1'b0;
        link_nak = 1'b0;
        forever begin
            @(negedge clk);
            if (fe_mode == FE_STALL) begin
                link_ack = 1'b1;
            end else if (fe_mode == FE_SILENT) begin
                link_ack = 1'b0;
                link_nak = 1'b0;
            end else if (fe_mode == FE_NORMAL) begin
                if (link_sent != (link_ack | link_nak)) begin
                    if (cnt >= ack_dly) begin
                        cnt = 0;
                        if (link_sent) begin
                            if (naks_left > 0) begin
                                link_nak = 1'b1;
                                naks_left--;
                            end else begin
                                link_ack = 1'b1;
                            end
                        end else begin
                            link_ack = 1'b0;
                            link_nak = 1'b0;
                        end
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor: one expected word per request strobe.
    initial begin
        logic prev = 1'b0;
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (link_sent && !prev) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_send: got %0h expected no transfer", link_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("link_word", link_data, e);
`ifdef OUT_LINK_PARITY_EN
                        check("link_par", link_par, ^e);
`endif
                    end
                end
                prev = link_sent;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic write_word(input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || link_sent || link_ack || link_nak) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", n < 1000, 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_rise(input string name);
        int n = 0;
        while (!link_sent && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, n < 100, 1);
    endtask

    initial begin
        int n;
        int k;
        logic [WIDTH-1:0] d;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_link_data", link_data, 0);
        check("rst_link_sent", link_sent, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_idle", idle, 1);

        // Single word, prompt ack: data after 1 cycle, strobe SETUP later.
        ack_dly = 1;
        exp_q.push_back(8'hA5);
        write_word(8'hA5);
        check("t1_level", level, 1);
        check("t1_idle_busy", idle, 0);
        @(negedge clk);
        check("t1_data", link_data, 8'hA5);
        check("t1_sent_lo0", link_sent, 0);
        @(negedge clk);
        check("t1_sent_lo1", link_sent, 0);
        @(negedge clk);
        check("t1_sent_hi", link_sent, 1);
        n = 0;
        while (!idle && n < 100) begin @(negedge clk); n++; end
        check("t1_idle_back", idle, 1);
        check("t1_ack_released", link_ack, 0);
        drain();

        // Stalled far end: fill to full, then overflow on the fifth word.
        fe_mode = FE_STALL;
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1;
            wr_data = WIDTH'(i);
            @(negedge clk);
            if (i <= DEPTH) exp_q.push_back(WIDTH'(i));
            if (i == 3) check("ovf_full_at3", full, 0);
            if (i == 4) begin
                check("ovf_full_at4", full, 1);
                check("ovf_level_at4", level, 4);
                check("ovf_flag_at4", err_ovf, 0);
            end
        end
        wr_en = 1'b0;
        check("ovf_flag_at5", err_ovf, 1);
        check("ovf_level_at5", level, 4);
        fe_mode = FE_NORMAL;
        drain();
        check("ovf_sticky", err_ovf, 1);
        pulse_clr();
        check("ovf_cleared", err_ovf, 0);

        // Silent far end: request held exactly TMO cycles, then next word.
        fe_mode = FE_SILENT;
        check("tmo_pre", err_timeout, 0);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        write_word(8'h3C);
        write_word(8'hC3);
        wait_rise("tmo_rise_seen");
        n = 0;
        while (link_sent && n < 100) begin n++; @(negedge clk); end
        check("tmo_req_len", n, TMO);
        check("tmo_flag", err_timeout, 1);
        fe_mode = FE_NORMAL;
        drain();
        check("tmo_sticky", err_timeout, 1);
        pulse_clr();
        check("tmo_cleared", err_timeout, 0);

        // Push in the same cycle as the FSM pop keeps level constant.
        fe_mode = FE_STALL;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        write_word(8'h11);
        write_word(8'h22);
        fe_mode = FE_MANUAL;
        @(negedge clk);
        link_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pp_level_before", level, 2);
        exp_q.push_back(8'h33);
        write_word(8'h33);
        check("pp_level_same", level, 2);
        check("pp_popped_head", link_data, 8'h11);
        fe_mode = FE_NORMAL;
        for (int i = 0; i < 6; i++) begin
            d = WIDTH'($urandom);
            exp_q.push_back(d);
            write_word(d);
            repeat (25) @(negedge clk);
        end
        drain();

        // Random bursts: one word leaves for the link at once, DEPTH more fit.
        for (int r = 0; r < 8; r++) begin
            ack_dly = $urandom_range(0, 3);
            k = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < k; i++) begin
                d = WIDTH'($urandom);
                if (i < DEPTH + 1) exp_q.push_back(d);
                wr_en = 1'b1;
                wr_data = d;
                @(negedge clk);
            end
            wr_en = 1'b0;
            check("rnd_ovf", err_ovf, (k > DEPTH + 1) ? 1 : 0);
            drain();
            pulse_clr();
        end
        ack_dly = 1;

        // Reset during a request discards the queue.
        fe_mode = FE_SILENT;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(WIDTH'(8'h50 + i));
            wr_en = 1'b1;
            wr_data = WIDTH'(8'h50 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_rise("rstq_rise_seen");
        check("rstq_level_pre", level, 3);
        #2 rst = 1'b1;
        #1;
        check("rstq_sent_async", link_sent, 0);
        check("rstq_level", level, 0);
        check("rstq_idle", idle, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        fe_mode = FE_NORMAL;
        repeat (30) @(negedge clk);
        check("rstq_level_after", level, 0);
        check("rstq_idle_after", idle, 1);

`ifdef OUT_LINK_PARITY_EN
        // Two NAKs then ack: three transfers, no error.
        naks_left = 2;
        repeat (3) exp_q.push_back(8'h07);
        write_word(8'h07);
        drain();
        check("par_nak2_err", err_timeout, 0);
        // Four NAKs: four transfers, then dropped with an error.
        naks_left = 4;
        repeat (4) exp_q.push_back(8'h07);
        write_word(8'h07);
        drain();
        check("par_nak4_err", err_timeout, 1);
        check("par_nak4_idle", idle, 1);
        pulse_clr();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/out_link_tx.md
Name: out_link_tx

Overview:
- Parametrised successor of the single-byte parallel link sender.
- Accepts words from the core into a small FIFO, then drives them one at a time onto a parallel inter-board link.
- Uses a full four-phase req/ack handshake with a programmable data-setup time and an ack timeout.
- Sits between the core output stage and the board-to-board connector pins.

Parameters:
- WIDTH, 8: link data width in bits.
- DEPTH, 4: FIFO depth in words; power of two, minimum 2.
- SETUP_CYCLES, 2: cycles link_data is held stable before link_sent rises; range 1..15.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for each ack edge before aborting the word; range 1..65535.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push wr_data into the FIFO this cycle.
- wr_data  in  WIDTH  word to send.
- full  out  1  FIFO full; combinational from the count.
- idle  out  1  FIFO empty AND FSM in IDLE (successor of isFinish).
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- link_data  out  WIDTH  registered link data bus.
- link_sent  out  1  registered request strobe to the far end.
- link_ack  in  1  acknowledge from the far end; asynchronous, double-flop synchronised internally.
- err_timeout  out  1  sticky timeout flag.
- err_ovf  out  1  sticky overflow flag.
- err_clr  in  1  single-cycle pulse that clears both sticky flags.

Behaviour:
- Reset values:
  - link_data=0, link_sent=0, err_timeout=0, err_ovf=0.
  - FIFO empty, so level=0, full=0, idle=1.
  - FSM in IDLE; synchroniser flops cleared.
- Clock/reset: one clock; reset is asynchronous and active-high, named rst; clock named clk.
- Reset mid-operation: link_sent drops immediately and the FIFO contents are discarded.
- FIFO writes:
  - wr_en with full=0 stores the word, and level increments next cycle.
  - wr_en with full=1 drops the word and sets err_ovf. This holds even if a pop happens in the same cycle, because full is evaluated on the pre-edge count.
- Simultaneous push and pop with level unchanged is legal.
- Pointers wrap modulo DEPTH.
- ack_s denotes link_ack after the 2-flop synchroniser (2-cycle latency).
- FSM states:
  - IDLE: if level>0 and ack_s=0, pop the head into link_data, load the setup counter, and go to SETUP. If ack_s=1 (the far end is still releasing), stay in IDLE.
  - SETUP: link_sent=0 and link_data stable. After SETUP_CYCLES cycles in this state, assert link_sent and go to REQ.
  - REQ: link_sent=1. On ack_s=1, deassert link_sent and go to RELEASE. If TIMEOUT_CYCLES elapse first, deassert link_sent, set err_timeout, and go to RELEASE; the word is discarded, not retried.
  - RELEASE: link_sent=0. On ack_s=0, go to IDLE. After a further TIMEOUT_CYCLES without ack_s=0, set err_timeout and go to IDLE anyway.
- The timeout counter is 16 bits and reloads on every state entry.
- Latency and throughput:
  - A word written at edge N into an empty, idle block appears on link_data at edge N+1.
  - link_sent rises at edge N+1+SETUP_CYCLES.
  - Back-to-back words are separated by at least the synchroniser delay of both ack edges.
- err_clr has priority over a set event in the same cycle.

Optional Feature:
- Macro OUT_LINK_PARITY_EN.
- When defined:
  - An extra output link_par (1 bit) carries the even parity of link_data. It is registered together with link_data and resets to 0.
  - An input link_nak (1 bit, synchronised like link_ack) is added. If nak_s=1 in REQ, the block deasserts link_sent, waits for both ack_s=0 and nak_s=0, then re-enters SETUP with the same word.
  - At most 3 resends per word; on the fourth NAK, err_timeout is set and the word is dropped.
- When undefined: neither port exists and behaviour is exactly as above.

Decomposition:
- Package out_link_pkg holds:
  - the FSM state enum (IDLE, SETUP, REQ, RELEASE);
  - the timeout counter width constant (16);
  - the synchroniser stage count (2);
  - the resend limit (3).
- One sub-module, out_link_fifo (parametrised WIDTH/DEPTH, with count/full/empty outputs). The FSM, synchroniser and counters stay in the top level.

Test Plan:
- Single word, immediate ack: write 0xA5 with SETUP_CYCLES=2 and a far end that acks 1 cycle after link_sent.
  - link_data=0xA5 one cycle after the write; link_sent rises 2 cycles later.
  - link_sent falls after ack_s; idle returns to 1 after ack is released.
- Burst/full/overflow: write 0x01..0x05 on consecutive cycles into DEPTH=4 with a stalled far end.
  - full=1 after the 4th write (level=4); the 5th write sets err_ovf.
  - Once the far end resumes, the link sees 0x01..0x04 in order.
- Ack timeout: TIMEOUT_CYCLES=10, far end never acks.
  - link_sent is high for exactly 10 cycles, then err_timeout=1.
  - The next queued word goes out afterwards; err_clr pulse returns err_timeout to 0.
- Reset mid-REQ: assert rst while link_sent=1 with 3 words queued.
  - link_sent=0 asynchronously, level=0, idle=1, and no word is sent after reset is released.
- Simultaneous push/pop: level=2, wr_en in the same cycle the FSM pops.
  - level stays 2, and word order is preserved across pointer wrap after 6 more words.
- Parity build (OUT_LINK_PARITY_EN): send 0x07.
  - link_par=1.
  - NAK twice then ack: 3 transfers of 0x07 with err_timeout=0.
  - NAK four times: err_timeout=1 and the word is dropped.
